ecdsa_sign_seq: RTL

Parametrised job sequencer in front of the ecdsa_sign core. It accepts messages over a valid/ready stream, queues up to DEPTH jobs and launches them one at a time into the core. It collects sign_u/sign_v with a per-job tag and status, and recovers the core on timeout. Successor to the bare message/done wiring: adds queueing, tagging, back-pressure, a watchdog and core reset.

---
 rtl/ecdsa_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/ecdsa_sign_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ecdsa_pkg.sv
// Shared definitions for the ECDSA signing job sequencer: FSM state encoding,
// result status codes and default data widths.
package ecdsa_pkg;

  localparam int unsigned MSG_W_DEF = 512;
  localparam int unsigned SIG_W_DEF = 233;

  localparam logic STATUS_OK      = 1'b0;
  localparam logic STATUS_TIMEOUT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RECOVER,
    S_EMIT
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
// Ports: clk/rst (sync, active-high), push/wdata, pop, head (entry at read
// pointer), full, empty, count.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ecdsa_sign_seq.sv
// Job sequencer in front of the ecdsa_sign core: queues tagged messages,
// launches them one at a time, collects u/v with status, and resets the core
// after a watchdog timeout.
// Ports: in_* message stream (valid/ready, tag of accepted beat), core_*
// core control/result, res_* result stream (valid/ready), busy, pending.
module ecdsa_sign_seq
  import ecdsa_pkg::*;
#(
  parameter  int unsigned MSG_W   = MSG_W_DEF,
  parameter  int unsigned SIG_W   = SIG_W_DEF,
  parameter  int unsigned DEPTH   = 4,
  parameter  int unsigned TAG_W   = 4,
  parameter  int unsigned TIMEOUT = 20000,
  parameter  int unsigned RST_CYC = 4,
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_msg,
  output logic [TAG_W-1:0] in_tag,
  output logic             core_nrst,
  output logic             core_start,
  output logic [MSG_W-1:0] core_msg,
  input  logic             core_done,
  input  logic [SIG_W-1:0] core_u,
  input  logic [SIG_W-1:0] core_v,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SIG_W-1:0] res_u,
  output logic [SIG_W-1:0] res_v,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_status,
  output logic             busy,
  output logic [CNT_W-1:0] pending
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d, job_tag_q, job_tag_d, res_tag_q, res_tag_d;
  logic [MSG_W-1:0]   core_msg_q, core_msg_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [SIG_W-1:0]   res_u_q, res_u_d, res_v_q, res_v_d;
  logic               res_status_q, res_status_d;
  logic               start_q, res_valid_q, busy_q, nrst_q;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [MSG_W+TAG_W-1:0] fifo_head;

  assign fifo_push = in_valid && in_ready;

  sync_fifo #(.W(MSG_W + TAG_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({tag_q, in_msg}),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    tag_d        = fifo_push ? tag_q + TAG_W'(1) : tag_q;
    job_tag_d    = job_tag_q;
    core_msg_d   = core_msg_q;
    wd_d         = wd_q;
    rc_d         = rc_q;
    res_u_d      = res_u_q;
    res_v_d      = res_v_q;
    res_tag_d    = res_tag_q;
    res_status_d = res_status_q;
    fifo_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          core_msg_d = fifo_head[MSG_W-1:0];
          job_tag_d  = fifo_head[MSG_W +: TAG_W];
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // wd_q == 0 marks the first WAIT cycle, where core_done is not trusted.
        if (core_done && (wd_q != '0)) begin
          res_u_d      = core_u;
          res_v_d      = core_v;
          res_tag_d    = job_tag_q;
          res_status_d = STATUS_OK;
          state_d      = S_EMIT;
        end else if ((TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1))) begin
          res_u_d      = '0;
          res_v_d      = '0;
          res_tag_d    = job_tag_q;
          res_status_d = STATUS_TIMEOUT;
          rc_d         = RC_W'(RST_CYC - 1);
          state_d      = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (rc_q == '0) state_d = S_EMIT;
        else            rc_d    = rc_q - RC_W'(1);
      end
      S_EMIT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; strobes are decoded from the next state so they align
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      job_tag_q    <= '0;
      core_msg_q   <= '0;
      wd_q         <= '0;
      rc_q         <= '0;
      res_u_q      <= '0;
      res_v_q      <= '0;
      res_tag_q    <= '0;
      res_status_q <= STATUS_OK;
      start_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      nrst_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      job_tag_q    <= job_tag_d;
      core_msg_q   <= core_msg_d;
      wd_q         <= wd_d;
      rc_q         <= rc_d;
      res_u_q      <= res_u_d;
      res_v_q      <= res_v_d;
      res_tag_q    <= res_tag_d;
      res_status_q <= res_status_d;
      start_q      <= (state_d == S_LAUNCH);
      res_valid_q  <= (state_d == S_EMIT);
      busy_q       <= (state_d != S_IDLE);
      nrst_q       <= (state_d != S_RECOVER);
    end
  end

  assign in_ready   = !fifo_full;
  assign in_tag     = tag_q;
  // The core is also held in reset while the sequencer itself is in reset.
  assign core_nrst  = nrst_q && !rst;
  assign core_start = start_q;
  assign core_msg   = core_msg_q;
  assign res_valid  = res_valid_q;
  assign res_u      = res_u_q;
  assign res_v      = res_v_q;
  assign res_tag    = res_tag_q;
  assign res_status = res_status_q;
  assign busy       = busy_q;

endmodule
